// File: rtl/circ_buffer_param.sv
// circ_buffer_param: parametrised circular FIFO with occupancy count, threshold flags, sticky errors and flush
module circ_buffer_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int AF_LEVEL  = DEPTH - 1,
  parameter int AE_LEVEL  = 1,
  parameter int OVERWRITE = 0,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_i,
  input  logic             rd_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             flush_i,
  input  logic             clear_err_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             dout_valid_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             almost_empty_o,
  output logic             almost_full_o,
  output logic [CW-1:0]    count_o,
  output logic             overflow_o,
  output logic             underflow_o,
  output logic [PW-1:0]    wr_ptr_out_o,
  output logic [PW-1:0]    rd_ptr_out_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dv_q, dv_d, ovf_q, ovf_d, udf_q, udf_d;
  logic             full, empty, do_rd, do_wr, ovw, ovf_set, udf_set;

  // status is decoded purely from the registered count
  assign full           = count_q == CW'(DEPTH);
  assign empty          = count_q == '0;
  assign empty_o        = empty;
  assign full_o         = full;
  assign almost_full_o  = count_q >= CW'(AF_LEVEL);
  assign almost_empty_o = count_q <= CW'(AE_LEVEL);
  assign count_o        = count_q;
  assign dout_o         = dout_q;
  assign dout_valid_o   = dv_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = udf_q;
  assign wr_ptr_out_o   = wr_ptr_q;
  assign rd_ptr_out_o   = rd_ptr_q;

  // accept decisions, error detection and next-state; flush overrides rd/wr
  always_comb begin
    do_rd    = rd_i && !empty && !flush_i;
    do_wr    = wr_i && (!full || rd_i || OVERWRITE != 0) && !flush_i;
    ovw      = OVERWRITE != 0 && wr_i && full && !rd_i && !flush_i;
    ovf_set  = wr_i && full && !rd_i && !flush_i;
    udf_set  = rd_i && empty && !flush_i;
    wr_ptr_d = flush_i ? '0 : !do_wr ? wr_ptr_q :
               (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    rd_ptr_d = flush_i ? '0 : !(do_rd || ovw) ? rd_ptr_q :
               (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    count_d  = flush_i ? '0 : count_q + CW'(do_wr && !ovw) - CW'(do_rd);
    dout_d   = do_rd ? mem_q[rd_ptr_q] : dout_q;
    dv_d     = do_rd;
    ovf_d    = ovf_set || (ovf_q && !clear_err_i);
    udf_d    = udf_set || (udf_q && !clear_err_i);
  end

  // control and output registers, cleared by asynchronous reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      dv_q     <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      dv_q     <= dv_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // storage array, deliberately left unreset
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= din_i;
  end
endmodule

// File: tb/tb_circ_buffer_param.sv
// tb_circ_buffer_param: directed self-checking bench for circ_buffer_param
module tb_circ_buffer_param;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  int checks = 0, errors = 0;

  logic       a_wr = 0, a_rd = 0, a_fl = 0, a_ce = 0;
  logic [2:0] a_din = 0;
  logic [2:0] o0_dout, o1_dout, o0_wp, o0_rp, o1_wp, o1_rp;
  logic       o0_dv, o0_e, o0_f, o0_ae, o0_af, o0_ov, o0_un;
  logic       o1_dv, o1_e, o1_f, o1_ae, o1_af, o1_ov, o1_un;
  logic [3:0] o0_cnt, o1_cnt;

  logic       b_wr = 0, b_rd = 0;
  logic [7:0] b_din = 0, o2_dout;
  logic       o2_dv, o2_e, o2_f, o2_ae, o2_af, o2_ov, o2_un;
  logic [2:0] o2_cnt, o2_wp, o2_rp;

  logic       c_wr = 0, c_rd = 0, c_fl = 0, c_ce = 0;
  logic [7:0] c_din = 0, o3_dout;
  logic       o3_dv, o3_e, o3_f, o3_ae, o3_af, o3_ov, o3_un;
  logic [3:0] o3_cnt;
  logic [2:0] o3_wp, o3_rp;

  circ_buffer_param #(.WIDTH(3), .DEPTH(8), .OVERWRITE(0)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .wr_i(a_wr), .rd_i(a_rd), .din_i(a_din), .flush_i(a_fl),
    .clear_err_i(a_ce), .dout_o(o0_dout), .dout_valid_o(o0_dv), .empty_o(o0_e), .full_o(o0_f),
    .almost_empty_o(o0_ae), .almost_full_o(o0_af), .count_o(o0_cnt), .overflow_o(o0_ov),
    .underflow_o(o0_un), .wr_ptr_out_o(o0_wp), .rd_ptr_out_o(o0_rp));

  circ_buffer_param #(.WIDTH(3), .DEPTH(8), .OVERWRITE(1)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .wr_i(a_wr), .rd_i(a_rd), .din_i(a_din), .flush_i(a_fl),
    .clear_err_i(a_ce), .dout_o(o1_dout), .dout_valid_o(o1_dv), .empty_o(o1_e), .full_o(o1_f),
    .almost_empty_o(o1_ae), .almost_full_o(o1_af), .count_o(o1_cnt), .overflow_o(o1_ov),
    .underflow_o(o1_un), .wr_ptr_out_o(o1_wp), .rd_ptr_out_o(o1_rp));

  circ_buffer_param #(.WIDTH(8), .DEPTH(5)) u2 (
    .clk_i(clk), .rst_ni(rst_n), .wr_i(b_wr), .rd_i(b_rd), .din_i(b_din), .flush_i(1'b0),
    .clear_err_i(1'b0), .dout_o(o2_dout), .dout_valid_o(o2_dv), .empty_o(o2_e), .full_o(o2_f),
    .almost_empty_o(o2_ae), .almost_full_o(o2_af), .count_o(o2_cnt), .overflow_o(o2_ov),
    .underflow_o(o2_un), .wr_ptr_out_o(o2_wp), .rd_ptr_out_o(o2_rp));

  circ_buffer_param #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) u3 (
    .clk_i(clk), .rst_ni(rst_n), .wr_i(c_wr), .rd_i(c_rd), .din_i(c_din), .flush_i(c_fl),
    .clear_err_i(c_ce), .dout_o(o3_dout), .dout_valid_o(o3_dv), .empty_o(o3_e), .full_o(o3_f),
    .almost_empty_o(o3_ae), .almost_full_o(o3_af), .count_o(o3_cnt), .overflow_o(o3_ov),
    .underflow_o(o3_un), .wr_ptr_out_o(o3_wp), .rd_ptr_out_o(o3_rp));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    errors++;
    $error("FAIL timeout: bench did not finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int sum0, sum1, vc0, vc1;
    #2;
    chk("rst_count", o0_cnt, 4'd0);
    chk("rst_empty", o0_e, 1'b1);
    chk("rst_ae", o0_ae, 1'b1);
    chk("rst_full", o0_f, 1'b0);
    chk("rst_dv", o0_dv, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    a_wr = 1; a_din = 3'b111;
    for (int i = 0; i < 7; i++) tick();
    a_din = 3'b110;
    tick();
    chk("fill_full0", o0_f, 1'b1);
    chk("fill_count0", o0_cnt, 4'd8);
    chk("fill_af0", o0_af, 1'b1);
    chk("fill_full1", o1_f, 1'b1);
    a_din = 3'b111;
    tick();
    chk("drop_ovf0", o0_ov, 1'b1);
    chk("drop_count0", o0_cnt, 4'd8);
    chk("drop_wp0", o0_wp, 3'd0);
    chk("ovw_ovf1", o1_ov, 1'b1);
    chk("ovw_count1", o1_cnt, 4'd8);
    chk("ovw_wp1", o1_wp, 3'd1);
    chk("ovw_rp1", o1_rp, 3'd1);

    a_wr = 0; a_rd = 1;
    sum0 = 0; sum1 = 0; vc0 = 0; vc1 = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      sum0 += int'(o0_dout); sum1 += int'(o1_dout);
      vc0 += int'(o0_dv); vc1 += int'(o1_dv);
      if (i == 6) chk("drain_d6_1", o1_dout, 3'b110);
    end
    chk("drain_last0", o0_dout, 3'b110);
    chk("drain_last1", o1_dout, 3'b111);
    chk("drain_sum0", sum0, 55);
    chk("drain_sum1", sum1, 55);
    chk("drain_vc0", vc0, 8);
    chk("drain_vc1", vc1, 8);
    chk("drain_empty0", o0_e, 1'b1);
    chk("drain_empty1", o1_e, 1'b1);
    tick();
    chk("udf0", o0_un, 1'b1);
    chk("udf_dv0", o0_dv, 1'b0);
    chk("udf_hold0", o0_dout, 3'b110);

    a_rd = 0; a_ce = 1;
    tick();
    chk("clr_ovf0", o0_ov, 1'b0);
    chk("clr_udf0", o0_un, 1'b0);
    a_ce = 0; a_rd = 1; a_wr = 1; a_din = 3'd5;
    tick();
    chk("rw_empty_cnt", o0_cnt, 4'd1);
    chk("rw_empty_udf", o0_un, 1'b1);
    chk("rw_empty_dv", o0_dv, 1'b0);
    a_rd = 0;
    for (int i = 1; i < 8; i++) begin
      a_din = 3'(i);
      tick();
    end
    chk("refill_cnt", o0_cnt, 4'd8);
    a_ce = 1; a_din = 3'd2;
    tick();
    chk("ce_ovf_wins", o0_ov, 1'b1);
    chk("ce_udf_clr", o0_un, 1'b0);
    chk("ce_ovf1", o1_ov, 1'b1);
    a_wr = 0;
    tick();
    chk("ce_ovf_clr", o0_ov, 1'b0);
    a_ce = 0; a_rd = 1; a_wr = 1; a_din = 3'd0;
    tick();
    chk("rw_full_cnt", o0_cnt, 4'd8);
    chk("rw_full_ovf", o0_ov, 1'b0);
    chk("rw_full_dout", o0_dout, 3'd5);
    chk("rw_full_dv", o0_dv, 1'b1);
    a_rd = 0; a_wr = 0;

    b_wr = 1;
    for (int i = 1; i <= 5; i++) begin
      b_din = 8'(i);
      tick();
    end
    chk("wrap_cnt5", o2_cnt, 3'd5);
    chk("wrap_full", o2_f, 1'b1);
    chk("wrap_wp", o2_wp, 3'd0);
    b_wr = 0; b_rd = 1;
    for (int i = 0; i < 3; i++) tick();
    chk("wrap_cnt2", o2_cnt, 3'd2);
    chk("wrap_rd3", o2_dout, 8'd3);
    chk("wrap_rp3", o2_rp, 3'd3);
    b_rd = 0; b_wr = 1;
    for (int i = 6; i <= 8; i++) begin
      b_din = 8'(i);
      tick();
    end
    chk("wrap_cnt5b", o2_cnt, 3'd5);
    chk("wrap_wp3", o2_wp, 3'd3);
    b_wr = 0; b_rd = 1;
    for (int i = 4; i <= 8; i++) begin
      tick();
      chk("wrap_drain", o2_dout, 8'(i));
    end
    chk("wrap_cnt0", o2_cnt, 3'd0);
    chk("wrap_rp_end", o2_rp, 3'd3);
    b_rd = 0;

    c_rd = 1;
    tick();
    chk("thr_udf", o3_un, 1'b1);
    c_rd = 0; c_wr = 1;
    for (int i = 1; i <= 6; i++) begin
      c_din = 8'(9 + i);
      tick();
      chk("thr_ae", o3_ae, i <= 2);
      chk("thr_af", o3_af, i >= 6);
    end
    c_wr = 0; c_rd = 1;
    for (int i = 0; i < 2; i++) tick();
    chk("fl_pre_cnt", o3_cnt, 4'd4);
    chk("fl_pre_dout", o3_dout, 8'd11);
    c_wr = 1; c_fl = 1;
    tick();
    chk("fl_cnt", o3_cnt, 4'd0);
    chk("fl_empty", o3_e, 1'b1);
    chk("fl_udf_kept", o3_un, 1'b1);
    chk("fl_dv", o3_dv, 1'b0);
    chk("fl_dout_hold", o3_dout, 8'd11);
    chk("fl_wp", o3_wp, 3'd0);
    c_fl = 0; c_rd = 0;
    for (int i = 0; i < 3; i++) begin
      c_din = 8'(40 + i);
      tick();
    end
    chk("mid_cnt", o3_cnt, 4'd3);
    c_wr = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_cnt", o3_cnt, 4'd0);
    chk("mrst_empty", o3_e, 1'b1);
    chk("mrst_ae", o3_ae, 1'b1);
    chk("mrst_dout", o3_dout, 8'd0);
    chk("mrst_udf", o3_un, 1'b0);
    chk("mrst_wp", o3_wp, 3'd0);
    chk("mrst_ovf0", o0_ov, 1'b0);
    chk("mrst_full0", o0_f, 1'b0);
    rst_n = 1'b1;
    c_wr = 1; c_din = 8'hA5;
    tick();
    chk("post_cnt", o3_cnt, 4'd1);
    c_wr = 0; c_rd = 1;
    tick();
    chk("post_dout", o3_dout, 8'hA5);
    chk("post_dv", o3_dv, 1'b1);
    chk("post_empty", o3_e, 1'b1);
    c_rd = 0;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
